fpu_result_queue: RTL and testbench

Coprocessor-side result stage between the FPU execution pipeline and the CORE-V-XIF result channel. Buffers completed results in order and tracks commit/kill status per instruction ID from the commit channel. Releases a result on `result_valid`/`result_ready` only once its ID is committed. Discards results whose ID was killed, without ever presenting them.

---
 rtl/fpu_pkg.sv | 45 ++++
 rtl/xif_commit_tracker.sv | 63 ++++++
 rtl/fpu_result_queue.sv | 201 ++++++++++++++++++++
 tb/tb_fpu_result_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: types and constants shared by the FPU result stage and the
// commit tracker.
//
// Contents:
//   RQ_ID_W, RQ_XLEN, RQ_FLEN  default widths of instruction ID and registers
//   RQ_DATA_W                  writeback data width, max(RQ_XLEN, RQ_FLEN)
//   rq_entry_t                 one buffered result (id, data, rd, we, exc, exccode)
//   HEAD_*                     classification of the queue head
//   head_state()               derives the head classification from status bits
package fpu_pkg;

  localparam int RQ_ID_W      = 4;
  localparam int RQ_XLEN      = 32;
  localparam int RQ_FLEN      = 32;
  localparam int RQ_DATA_W    = (RQ_XLEN > RQ_FLEN) ? RQ_XLEN : RQ_FLEN;
  localparam int RQ_RD_W      = 5;
  localparam int RQ_EXCCODE_W = 6;

  typedef struct packed {
    logic [RQ_ID_W-1:0]      id;
    logic [RQ_DATA_W-1:0]    data;
    logic [RQ_RD_W-1:0]      rd;
    logic                    we;
    logic                    exc;
    logic [RQ_EXCCODE_W-1:0] exccode;
  } rq_entry_t;

  // Head classification; HEAD_EMPTY covers the no-entry case.
  localparam logic [1:0] HEAD_EMPTY = 2'd0;
  localparam logic [1:0] HEAD_WAIT  = 2'd1;
  localparam logic [1:0] HEAD_OUT   = 2'd2;
  localparam logic [1:0] HEAD_DROP  = 2'd3;

  function automatic logic [1:0] head_state(input logic empty,
                                            input logic done,
                                            input logic kill);
    logic [1:0] st;
    if (empty)      st = HEAD_EMPTY;
    else if (!done) st = HEAD_WAIT;
    else if (kill)  st = HEAD_DROP;
    else            st = HEAD_OUT;
    return st;
  endfunction

endpackage

// File: rtl/xif_commit_tracker.sv
// xif_commit_tracker: per-instruction-ID done/kill status table fed by the
// CORE-V-XIF commit channel.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   set_valid/id/kill      commit strobe: done[id]=1, kill[id]=set_kill
//   clr_valid/id           retire: clears done[id] and kill[id]
//   lookup_id[N_LOOKUP]    IDs to look up
//   lookup_done/kill       status of each looked-up ID (from registered state)
//
// A set and a clear to the same ID in one cycle resolve in favour of the set:
// the commit belongs to the next instance of that ID, the clear to the one
// being retired.
module xif_commit_tracker #(
  parameter int ID_W     = 4,
  parameter int N_LOOKUP = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          set_valid,
  input  logic [ID_W-1:0]               set_id,
  input  logic                          set_kill,
  input  logic                          clr_valid,
  input  logic [ID_W-1:0]               clr_id,
  input  logic [N_LOOKUP-1:0][ID_W-1:0] lookup_id,
  output logic [N_LOOKUP-1:0]           lookup_done,
  output logic [N_LOOKUP-1:0]           lookup_kill
);

  localparam int N_IDS = 1 << ID_W;

  logic [N_IDS-1:0] done_reg;
  logic [N_IDS-1:0] kill_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_IDS; gi++) begin : g_id
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_valid && (set_id == ID_W'(gi));
      assign clr_hit = clr_valid && (clr_id == ID_W'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          done_reg[gi] <= 1'b0;
          kill_reg[gi] <= 1'b0;
        end else if (set_hit) begin
          done_reg[gi] <= 1'b1;
          kill_reg[gi] <= set_kill;
        end else if (clr_hit) begin
          done_reg[gi] <= 1'b0;
          kill_reg[gi] <= 1'b0;
        end
      end
    end

    for (gi = 0; gi < N_LOOKUP; gi++) begin : g_lookup
      assign lookup_done[gi] = done_reg[lookup_id[gi]];
      assign lookup_kill[gi] = kill_reg[lookup_id[gi]];
    end
  endgenerate

endmodule

// File: rtl/fpu_result_queue.sv
// fpu_result_queue: in-order result buffer between the FPU pipeline and the
// CORE-V-XIF result channel. A result is released only after its ID has been
// committed; results whose ID was killed are dropped without being presented.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            pipeline result handshake (in_ready = !full)
//   in_id/data/rd/we/exc/exccode result fields from the pipeline
//   commit_valid/id/kill         commit channel
//   result_valid/result_ready    CPU result handshake
//   result_id/data/rd/we/exc/exccode  head entry fields
//
// Build option: FPU_RESULT_QUEUE_BYPASS_EN. When defined, a result arriving
// at an empty queue whose ID is already committed is presented in the same
// cycle (and consumed without storage if accepted); an already-killed one is
// discarded on arrival. Without it, result_* depend on registered state only.
//
// Entry widths come from fpu_pkg; the width parameters must match the package.
module fpu_result_queue
  import fpu_pkg::*;
#(
  parameter int X_ID_WIDTH = RQ_ID_W,
  parameter int XLEN       = RQ_XLEN,
  parameter int FLEN       = RQ_FLEN,
  parameter int DEPTH      = 4,
  localparam int DATA_W    = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [X_ID_WIDTH-1:0] in_id,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [4:0]            in_rd,
  input  logic                  in_we,
  input  logic                  in_exc,
  input  logic [5:0]            in_exccode,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [DATA_W-1:0]     result_data,
  output logic [4:0]            result_rd,
  output logic                  result_we,
  output logic                  result_exc,
  output logic [5:0]            result_exccode
);

  localparam int PTR_W = $clog2(DEPTH);

`ifdef FPU_RESULT_QUEUE_BYPASS_EN
  localparam int N_LOOKUP = 2;   // head ID and incoming ID
`else
  localparam int N_LOOKUP = 1;   // head ID only
`endif

  rq_entry_t          mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [PTR_W:0]     count_next;

  rq_entry_t          head;
  rq_entry_t          in_entry;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [1:0]         head_st;
  logic               head_out;
  logic               head_drop;

  logic                                clr_valid;
  logic [X_ID_WIDTH-1:0]               clr_id;
  logic [N_LOOKUP-1:0][X_ID_WIDTH-1:0] lookup_id;
  logic [N_LOOKUP-1:0]                 lookup_done;
  logic [N_LOOKUP-1:0]                 lookup_kill;

  // ---------------------------------------------------------------- status
  xif_commit_tracker #(
    .ID_W     (X_ID_WIDTH),
    .N_LOOKUP (N_LOOKUP)
  ) u_tracker (
    .clk         (clk),
    .reset_n     (reset_n),
    .set_valid   (commit_valid),
    .set_id      (commit_id),
    .set_kill    (commit_kill),
    .clr_valid   (clr_valid),
    .clr_id      (clr_id),
    .lookup_id   (lookup_id),
    .lookup_done (lookup_done),
    .lookup_kill (lookup_kill)
  );

  // ---------------------------------------------------------------- head
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign head      = mem_reg[rd_ptr_reg];
  assign head_st   = head_state(empty, lookup_done[0], lookup_kill[0]);
  assign head_out  = (head_st == HEAD_OUT);
  assign head_drop = (head_st == HEAD_DROP);

  // A killed head leaves unconditionally; a committed one waits for the CPU.
  assign pop       = (head_out && result_ready) || head_drop;
  assign in_ready  = !full;

  always_comb begin
    in_entry         = '0;
    in_entry.id      = in_id;
    in_entry.data    = in_data;
    in_entry.rd      = in_rd;
    in_entry.we      = in_we;
    in_entry.exc     = in_exc;
    in_entry.exccode = in_exccode;
  end

`ifdef FPU_RESULT_QUEUE_BYPASS_EN
  logic bypass_hit;
  logic bypass_take;
  logic bypass_kill;
  rq_entry_t out_entry;

  assign lookup_id[0] = head.id;
  assign lookup_id[1] = in_id;

  // Only an empty queue may be bypassed, so ordering is preserved and the
  // head retire port is idle whenever the bypass needs the clear port.
  assign bypass_hit  = empty && in_valid && lookup_done[1] && !lookup_kill[1];
  assign bypass_kill = empty && in_valid && lookup_done[1] &&  lookup_kill[1];
  assign bypass_take = bypass_hit && result_ready;

  assign push         = in_valid && !full && !bypass_take && !bypass_kill;
  assign result_valid = head_out || bypass_hit;
  assign out_entry    = bypass_hit ? in_entry : head;
  assign clr_valid    = pop || bypass_take || bypass_kill;
  assign clr_id       = pop ? head.id : in_id;

  assign result_id      = out_entry.id;
  assign result_data    = out_entry.data;
  assign result_rd      = out_entry.rd;
  assign result_we      = out_entry.we;
  assign result_exc     = out_entry.exc;
  assign result_exccode = out_entry.exccode;
`else
  assign lookup_id[0] = head.id;

  assign push         = in_valid && !full;
  assign result_valid = head_out;
  assign clr_valid    = pop;
  assign clr_id       = head.id;

  assign result_id      = head.id;
  assign result_data    = head.data;
  assign result_rd      = head.rd;
  assign result_we      = head.we;
  assign result_exc     = head.exc;
  assign result_exccode = head.exccode;
`endif

  // ---------------------------------------------------------------- storage
  // Entries are reset so the result_* fields read zero out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= in_entry;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- pointers
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers are log2(DEPTH) bits and wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb_fpu_result_queue: directed-vector bench for fpu_result_queue (default
// build, no bypass). Inputs change 1 time unit after the rising edge and
// outputs are compared at that point, before the next edge.
module tb_fpu_result_queue;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_id;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        in_exc;
  logic [5:0]  in_exccode;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic        result_exc;
  logic [5:0]  result_exccode;

  int n_vec;
  int n_err;

  fpu_result_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_id          (in_id),
    .in_data        (in_data),
    .in_rd          (in_rd),
    .in_we          (in_we),
    .in_exc         (in_exc),
    .in_exccode     (in_exccode),
    .commit_valid   (commit_valid),
    .commit_id      (commit_id),
    .commit_kill    (commit_kill),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_id      (result_id),
    .result_data    (result_data),
    .result_rd      (result_rd),
    .result_we      (result_we),
    .result_exc     (result_exc),
    .result_exccode (result_exccode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_id        = '0;
    in_data      = '0;
    in_rd        = '0;
    in_we        = 1'b0;
    in_exc       = 1'b0;
    in_exccode   = '0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // One-cycle commit strobe.
  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    step();
    commit_valid = 1'b0;
  endtask

  // One-cycle push; the queue is known to have room at each call site.
  task automatic push(input logic [3:0] id, input logic [31:0] data);
    in_valid = 1'b1;
    in_id    = id;
    in_data  = data;
    in_rd    = 5'd10;
    in_we    = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_id;
    logic       exp_rdy [5];
    n_vec = 0;
    n_err = 0;
    exp_rdy[0] = 1'b0;
    exp_rdy[1] = 1'b1;
    exp_rdy[2] = 1'b1;
    exp_rdy[3] = 1'b1;
    exp_rdy[4] = 1'b1;

    // ---- reset state (checked while reset is held)
    idle_inputs();
    reset_n = 1'b0;
    step();
    check_eq("rst_valid",  64'(result_valid), 64'd0);
    check_eq("rst_ready",  64'(in_ready),     64'd1);
    check_eq("rst_id",     64'(result_id),    64'd0);
    check_eq("rst_data",   64'(result_data),  64'd0);
    check_eq("rst_rd_we",  64'({result_rd, result_we, result_exc, result_exccode}), 64'd0);
    reset_n = 1'b1;
    step();

    // ---- commit before result
    commit(4'd3, 1'b0);
    step();
    push(4'd3, 32'h3F80_0000);
    check_eq("cbr_valid", 64'(result_valid), 64'd1);
    check_eq("cbr_id",    64'(result_id),    64'd3);
    check_eq("cbr_data",  64'(result_data),  64'h3F80_0000);
    check_eq("cbr_rd",    64'(result_rd),    64'd10);
    step();
    check_eq("cbr_hold",  64'(result_valid), 64'd1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check_eq("cbr_popped", 64'(result_valid), 64'd0);

    // ---- result before commit
    do_reset();
    push(4'd5, 32'h4000_0000);
    result_ready = 1'b1;
    check_eq("rbc_wait0", 64'(result_valid), 64'd0);
    step();
    check_eq("rbc_wait1", 64'(result_valid), 64'd0);
    step();
    check_eq("rbc_wait2", 64'(result_valid), 64'd0);
    step();
    check_eq("rbc_wait3", 64'(result_valid), 64'd0);
    commit(4'd5, 1'b0);
    check_eq("rbc_valid", 64'(result_valid), 64'd1);
    check_eq("rbc_id",    64'(result_id),    64'd5);
    step();
    check_eq("rbc_once",  64'(result_valid), 64'd0);
    result_ready = 1'b0;

    // ---- kill at head
    do_reset();
    push(4'd1, 32'h1111_1111);
    push(4'd2, 32'h2222_2222);
    check_eq("kill_wait", 64'(result_valid), 64'd0);
    commit(4'd1, 1'b1);
    // head id 1 is being dropped this cycle
    check_eq("kill_drop_valid", 64'(result_valid), 64'd0);
    commit(4'd2, 1'b0);
    check_eq("kill_next_valid", 64'(result_valid), 64'd1);
    check_eq("kill_next_id",    64'(result_id),    64'd2);
    check_eq("kill_next_data",  64'(result_data),  64'h2222_2222);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check_eq("kill_empty", 64'(result_valid), 64'd0);

    // ---- full and backpressure
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_id   = 4'(k);
      in_data = 32'hA000_0000 + 32'(k);
      check_eq($sformatf("full_rdy_%0d", k), 64'(in_ready), 64'd1);
      step();
    end
    in_id   = 4'd4;
    in_data = 32'hA000_0004;
    check_eq("full_rdy_4", 64'(in_ready), 64'd0);
    // commits for ids 0..4 while id 4 is held upstream
    for (int k = 0; k < 5; k++) begin
      commit(4'(k), 1'b0);
      check_eq($sformatf("full_hold_%0d", k), 64'(in_ready), 64'd0);
    end
    result_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_id = 4'(k);
      check_eq($sformatf("drain_valid_%0d", k), 64'(result_valid), 64'd1);
      check_eq($sformatf("drain_id_%0d", k),    64'(result_id),    64'(exp_id));
      check_eq($sformatf("drain_rdy_%0d", k),   64'(in_ready),     64'(exp_rdy[k]));
      step();
      if (k == 1) in_valid = 1'b0;   // id 4 was taken on that edge
    end
    result_ready = 1'b0;
    check_eq("drain_empty", 64'(result_valid), 64'd0);
    check_eq("drain_ready", 64'(in_ready),     64'd1);

    // ---- ID reuse collision: pop of id 7 and new commit of id 7 together
    do_reset();
    push(4'd7, 32'h7777_0001);
    commit(4'd7, 1'b0);
    check_eq("reuse_first", 64'(result_valid), 64'd1);
    result_ready = 1'b1;
    commit(4'd7, 1'b0);
    result_ready = 1'b0;
    check_eq("reuse_gap", 64'(result_valid), 64'd0);
    push(4'd7, 32'h7777_0002);
    check_eq("reuse_valid", 64'(result_valid), 64'd1);
    check_eq("reuse_data",  64'(result_data),  64'h7777_0002);

    // ---- asynchronous reset mid-stream
    do_reset();
    commit(4'd1, 1'b0);
    push(4'd1, 32'hB000_0001);
    push(4'd2, 32'hB000_0002);
    push(4'd3, 32'hB000_0003);
    check_eq("arst_pre_valid", 64'(result_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(result_valid), 64'd0);
    check_eq("arst_ready", 64'(in_ready),     64'd1);
    check_eq("arst_data",  64'(result_data),  64'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("arst_after_valid", 64'(result_valid), 64'd0);
    // status table was cleared too: id 1 must wait for a fresh commit
    push(4'd1, 32'hB000_0011);
    check_eq("arst_table_clear", 64'(result_valid), 64'd0);
    commit(4'd1, 1'b0);
    check_eq("arst_recommit_id", 64'(result_id), 64'd1);
    check_eq("arst_recommit_data", 64'(result_data), 64'hB000_0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
